// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake and status bundle of the parametrised FIFO
interface sync_fifo_param_if #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    din;
  logic                din_dv;
  logic                din_rdy;
  logic [WIDTH-1:0]    dout;
  logic                dout_dv;
  logic                dout_rdy;
  logic [DEPTH_LOG2:0] level;
  logic                afull;
  logic                aempty;
  logic                overflow;
  modport master (
    output din, din_dv, dout_rdy,
    input  din_rdy, dout, dout_dv, level, afull, aempty, overflow
  );
  modport slave (
    input  din, din_dv, dout_rdy,
    output din_rdy, dout, dout_dv, level, afull, aempty, overflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with FWFT or read-request output, level/threshold flags, sticky overflow and flush
module sync_fifo_param #(
  parameter int WIDTH         = 10,
  parameter int DEPTH_LOG2    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  input logic            clr_i,
  sync_fifo_param_if.slave f
);
  localparam int depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] full_lvl   = depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] afull_lvl  = AFULL_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] aempty_lvl = AEMPTY_THRESH[DEPTH_LOG2:0];
  logic [WIDTH-1:0]    mem_q [depth];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_dv_q, dout_dv_d, din_rdy_q, din_rdy_d;
  logic                afull_q, afull_d, aempty_q, aempty_d, ovf_q, ovf_d;
  logic                mem_empty, wr, rd, load;
  // In FWFT mode the output register holds the head and is part of LEVEL;
  // the memory refills it whenever it is empty or being consumed.
  // In read-request mode a request pops the memory straight into DOUT.
  always_comb begin
    mem_empty = wptr_q == rptr_q;
    wr        = f.din_dv && din_rdy_q;
    rd        = FWFT != 0 ? dout_dv_q && f.dout_rdy : f.dout_rdy && !mem_empty;
    load      = FWFT != 0 ? !mem_empty && (!dout_dv_q || rd) : rd;
    wptr_d    = clr_i ? '0 : wptr_q + (DEPTH_LOG2+1)'(wr);
    rptr_d    = clr_i ? '0 : rptr_q + (DEPTH_LOG2+1)'(load);
    level_d   = clr_i ? '0 : level_q + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
    dout_d    = load && !clr_i ? mem_q[rptr_q[DEPTH_LOG2-1:0]] : dout_q;
    dout_dv_d = clr_i ? 1'b0 : FWFT != 0 ? (load ? 1'b1 : rd ? 1'b0 : dout_dv_q) : load;
    din_rdy_d = level_d != full_lvl;
    afull_d   = level_d >= afull_lvl;
    aempty_d  = level_d <= aempty_lvl;
    ovf_d     = clr_i ? 1'b0 : ovf_q || (f.din_dv && !din_rdy_q);
  end
  // State and registered flags; flags are derived from next LEVEL so they track it cycle-exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      dout_q    <= '0;
      dout_dv_q <= 1'b0;
      din_rdy_q <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      dout_q    <= dout_d;
      dout_dv_q <= dout_dv_d;
      din_rdy_q <= din_rdy_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
    end
  end
  // Storage array; contents survive reset and flush, only the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (wr && !clr_i) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= f.din;
  end
  assign f.din_rdy  = din_rdy_q;
  assign f.dout     = dout_q;
  assign f.dout_dv  = dout_dv_q;
  assign f.level    = level_q;
  assign f.afull    = afull_q;
  assign f.aempty   = aempty_q;
  assign f.overflow = ovf_q;
endmodule
